fp_mult_result_buffer: RTL and testbench
========================================

Name: fp_mult_result_buffer

Overview:
- Downstream stage of `fp_mult_top`.
- Tracks multiplications issued into the fixed-latency multiplier and captures each returning `z`/`status` pair exactly LATENCY cycles after issue.
- Queues results in a small circular FIFO and drains them through a valid/ready port.
- Gives the issuer a credit-based `issue_ready`, so the non-stallable multiplier never produces a result with no room to hold it.
- Also accumulates sticky exception flags and counts delivered results.

Parameters:
- ROUND, IEEE_near, rounding mode (`round_values`) of the attached multiplier; informational only, echoed on `round_mode`.
- LATENCY, 2, cycles from the multiplier's operand sample to a valid `z`/`status` (≥1).
- DEPTH, 4, FIFO entries (power of two, ≥ LATENCY).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue  in  1  issuer presents operands to the multiplier this cycle.
- issue_ready  out  1  an issue this cycle is accepted.
- mult_z  in  32  `z` from the multiplier.
- mult_status  in  8  `status` from the multiplier.
- out_valid  out  1  `out_z`/`out_status` hold a result.
- out_ready  in  1  consumer accepts the result.
- out_z  out  32  head-of-FIFO result.
- out_status  out  8  head-of-FIFO status.
- clear  in  1  synchronous clear of accumulated flags and error.
- acc_status  out  8  OR of the status of every delivered result since the last clear.
- err_overflow  out  1  sticky flag: an issue was attempted while `issue_ready`=0.
- result_count  out  16  count of delivered results; wraps.
- round_mode  out  3  ROUND encoding; constant.

Behaviour:
- Reset (`rst`=0, asynchronous): the following all go to 0:
  - the in-flight shift register;
  - FIFO pointers and occupancy;
  - `out_valid`, `out_z`, `out_status`;
  - `acc_status`, `err_overflow`, `result_count`.
- `issue_ready` after reset is 1. Reset mid-operation discards in-flight and queued results.
- Accepted issue = `issue` && `issue_ready`.
- In-flight tracking:
  - A LATENCY-deep shift register of accepted-issue bits.
  - Its tail bit `cap` is 1 exactly LATENCY cycles after an accepted issue.
  - When `cap`=1, `mult_z`/`mult_status` are written into the FIFO at the write pointer that cycle.
  - `mult_*` inputs are ignored when `cap`=0.
- Credit: `issue_ready` = (occupancy + inflight) < DEPTH.
  - `inflight` = popcount of the shift register. Registered counters are kept; no combinational popcount.
  - `issue_ready` is combinational from registered counters only. It does not depend on `issue`, `out_ready` or `clear`.
- An issue with `issue_ready`=0 is dropped and never enters the shift register. `err_overflow` is set the next cycle.
- FIFO:
  - Circular buffer; write and read pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Push while full cannot occur by construction; the bench asserts this.
  - Pop while empty is impossible because pop = `out_valid` && `out_ready`.
- Output:
  - `out_valid` = occupancy > 0; `out_z`/`out_status` are the head entry, read from registered storage.
  - No bypass: a result captured at edge t is visible on the output after edge t. Issue-to-`out_valid` is LATENCY+1 cycles.
  - `out_z`/`out_status` stay stable while `out_valid`=1 and `out_ready`=0.
- Delivery (`out_valid` && `out_ready`):
  - `acc_status` |= `out_status`;
  - `result_count` += 1, 0xFFFF wraps to 0x0000.
- Clear:
  - `clear`=1 zeroes `acc_status` and `err_overflow`; `result_count` is not affected.
  - Clear and delivery in the same cycle: `acc_status` becomes exactly the delivered `out_status`.
  - Clear and overflow in the same cycle: `err_overflow` = 1.
- Status bit layout: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] reserved (passed through and accumulated like the others).
- Full credit with DEPTH=4: four back-to-back issues are accepted; a fifth is refused until one delivery.

Decomposition:
- Shared package `fp_mult_pkg`:
  - `round_values` enum;
  - status bit index constants (STATUS_ZERO … STATUS_INEXACT);
  - `fp32_t` typedef (sign, exp[7:0], frac[22:0]).
- One sub-module, `fp_mult_inflight_tracker`: the LATENCY-deep shift register plus inflight counter. Outputs `cap` and `inflight`.

Test Plan:
- Reset at t=5 ns during two in-flight issues -> `out_valid`=0, `inflight`=0, `issue_ready`=1 immediately, no later captures.
- Single issue, 0x3F800000×0x40000000, LATENCY=2, `out_ready`=1 -> `out_valid`=1 for one cycle, exactly 3 cycles after issue.
  - `out_z`=0x40000000, `out_status`=0x00, `result_count`=1.
- Six consecutive issues with `out_ready`=0 -> first four accepted, `issue_ready`=0 afterwards.
  - `err_overflow`=1 after issue 5.
  - Then `out_ready`=1 drains exactly 4 results in issue order.
- Results carrying status 0x20 then 0x02 delivered -> `acc_status`=0x22.
  - `clear` in the same cycle as a 0x04 delivery -> `acc_status`=0x04.
- Continuous issue with `out_ready` toggling every cycle, 1000 random operand pairs -> no FIFO push-while-full assertion fires.
  - Output order matches the issue order against a reference queue; `result_count`=1000.
- `result_count` preloaded by 65535 deliveries, one more delivery -> `result_count`=0x0000; `acc_status` unaffected.

Source files
------------

// File: rtl/fp_mult_pkg.sv
`timescale 1ns/1ps
// Types and constants shared by the fp_mult datapath and its result buffer.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        IEEE_near    = 3'd0,
        IEEE_zero    = 3'd1,
        IEEE_pos_inf = 3'd2,
        IEEE_neg_inf = 3'd3,
        near_up      = 3'd4,
        away_zero    = 3'd5
    } round_values;

    // Bit positions inside the 8-bit multiplier status word; [7:6] are reserved.
    localparam int STATUS_ZERO    = 0;
    localparam int STATUS_INF     = 1;
    localparam int STATUS_NAN     = 2;
    localparam int STATUS_TINY    = 3;
    localparam int STATUS_HUGE    = 4;
    localparam int STATUS_INEXACT = 5;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_mult_inflight_tracker.sv
`timescale 1ns/1ps
// Follows accepted issues through the fixed-latency multiplier: raises cap when a
// result is due and keeps a running count of issues still in the pipe.
module fp_mult_inflight_tracker #(
    parameter int LATENCY = 2,
    parameter int IW      = $clog2(LATENCY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    output logic          cap,
    output logic [IW-1:0] inflight
);
    logic [LATENCY-1:0] pipe;
    logic [LATENCY-1:0] accept_vec;

    always_comb begin
        accept_vec    = '0;
        accept_vec[0] = accept;
    end

    assign cap = pipe[LATENCY-1];

    // Counter mirrors popcount(pipe): a bit enters on accept and leaves as cap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe     <= '0;
            inflight <= '0;
        end else begin
            pipe <= (pipe << 1) | accept_vec;
            if (accept && !cap)
                inflight <= inflight + 1'b1;
            else if (!accept && cap)
                inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_result_buffer.sv
`timescale 1ns/1ps
// Captures fixed-latency multiplier results into a small FIFO, drains them over
// valid/ready, and grants issue credit so no result ever arrives without a slot.
module fp_mult_result_buffer
    import fp_mult_pkg::*;
#(
    parameter round_values ROUND   = IEEE_near,
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    output logic        issue_ready,
    input  logic [31:0] mult_z,
    input  logic [7:0]  mult_status,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic [7:0]  out_status,
    input  logic        clear,
    output logic [7:0]  acc_status,
    output logic        err_overflow,
    output logic [15:0] result_count,
    output logic [2:0]  round_mode
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic          accept;
    logic          cap;
    logic          pop;
    logic [IW-1:0] inflight;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    fp32_t         mem_z  [DEPTH];
    logic [7:0]    mem_st [DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts queued results plus those still inside the multiplier.
    assign issue_ready = (SW'(occ) + SW'(inflight)) < SW'(DEPTH);
    assign accept      = issue && issue_ready;
    assign out_valid   = (occ != '0);
    assign pop         = out_valid && out_ready;
    assign out_z       = mem_z[rd_ptr];
    assign out_status  = mem_st[rd_ptr];
    assign round_mode  = ROUND;

    fp_mult_inflight_tracker #(
        .LATENCY (LATENCY),
        .IW      (IW)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .cap      (cap),
        .inflight (inflight)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_z[i]  <= '0;
                mem_st[i] <= '0;
            end
        end else begin
            if (cap) begin
                mem_z[wr_ptr]  <= mult_z;
                mem_st[wr_ptr] <= mult_status;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (cap && !pop)
                occ <= occ + 1'b1;
            else if (pop && !cap)
                occ <= occ - 1'b1;
        end
    end

    // A clear coinciding with a delivery keeps only the delivered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_status   <= '0;
            err_overflow <= 1'b0;
            result_count <= '0;
        end else begin
            if (pop)
                result_count <= result_count + 16'd1;
            if (clear)
                acc_status <= pop ? out_status : 8'h00;
            else if (pop)
                acc_status <= acc_status | out_status;
            err_overflow <= (err_overflow && !clear) || (issue && !issue_ready);
        end
    end

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
`timescale 1ns/1ps
// Bench for fp_mult_result_buffer: a stub multiplier pipeline, a queue-based
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_fp_mult_result_buffer;
    import fp_mult_pkg::*;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue = 1'b0;
    logic        issue_ready;
    logic [31:0] mult_z;
    logic [7:0]  mult_status;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic        clear = 1'b0;
    logic [7:0]  acc_status;
    logic        err_overflow;
    logic [15:0] result_count;
    logic [2:0]  round_mode;

    logic [31:0] iss_z  = '0;
    logic [7:0]  iss_st = '0;

    int total = 0;
    int bad   = 0;

    fp_mult_result_buffer #(
        .ROUND   (IEEE_near),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .issue_ready  (issue_ready),
        .mult_z       (mult_z),
        .mult_status  (mult_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_status   (out_status),
        .clear        (clear),
        .acc_status   (acc_status),
        .err_overflow (err_overflow),
        .result_count (result_count),
        .round_mode   (round_mode)
    );

    always #1 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub multiplier: result appears LATENCY cycles after the operand sample;
    // junk is driven whenever nothing was issued.
    logic [39:0] stub [LATENCY];
    always @(posedge clk) begin
        stub[0] <= issue ? {iss_z, iss_st} : {$urandom, 8'($urandom)};
        for (int i = 1; i < LATENCY; i++)
            stub[i] <= stub[i-1];
    end
    assign {mult_z, mult_status} = stub[LATENCY-1];

    // Reference model: every accepted issue becomes visible LATENCY+1 cycles later.
    typedef struct {
        longint      rdy;
        logic [31:0] z;
        logic [7:0]  st;
    } exp_t;

    exp_t        q[$];
    longint      cyc = 0;
    int          n_acc = 0;
    logic [7:0]  m_acc = '0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        m_ready;
    logic        m_valid;

    always @(negedge rst) begin
        q.delete();
        m_acc = '0;
        m_err = 1'b0;
        m_cnt = '0;
        n_acc = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ready = q.size() < DEPTH;
            m_valid = (q.size() > 0) && (q[0].rdy <= cyc);
            if (m_valid && out_ready) begin
                m_acc = (clear ? 8'h00 : m_acc) | q[0].st;
                m_cnt = m_cnt + 16'd1;
                void'(q.pop_front());
            end else if (clear) begin
                m_acc = 8'h00;
            end
            m_err = (m_err && !clear) || (issue && !m_ready);
            if (issue && m_ready) begin
                q.push_back('{rdy: cyc + LATENCY + 1, z: iss_z, st: iss_st});
                n_acc++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst) begin
            logic ev;
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("issue_ready", 32'(issue_ready), 32'(q.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                chk("out_z", out_z, q[0].z);
                chk("out_status", 32'(out_status), 32'(q[0].st));
            end
            chk("acc_status", 32'(acc_status), 32'(m_acc));
            chk("err_overflow", 32'(err_overflow), 32'(m_err));
            chk("result_count", 32'(result_count), 32'(m_cnt));
            chk("push_while_full", 32'(dut.cap && (int'(dut.occ) == DEPTH)), 32'(0));
        end
    end

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && q.size() != 0; k++)
            @(negedge clk);
        chk(name, 32'(q.size()), 32'(0));
    endtask

    initial begin
        // Reset state, then reset at t=5 ns with two issues inside the multiplier.
        #0.1 rst = 1'b0;
        #0.2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_issue_ready", 32'(issue_ready), 32'(1));
        chk("rst_out_z", out_z, 32'h0);
        chk("rst_count", 32'(result_count), 32'(0));
        chk("rst_round_mode", 32'(round_mode), 32'(0));
        #0.2 rst = 1'b1;
        issue = 1'b1;
        iss_z = 32'h1111_1111;
        #1.0 iss_z = 32'h2222_2222;
        #2.5 issue = 1'b0;
        #1.0 rst = 1'b0;
        #0.5;
        chk("midrst_inflight", 32'(dut.inflight), 32'(0));
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_issue_ready", 32'(issue_ready), 32'(1));
        @(negedge clk) rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_late_capture", 32'(out_valid), 32'(0));
        end

        // 1.0 x 2.0 = 2.0: visible exactly three cycles after issue, for one cycle.
        out_ready = 1'b1;
        issue = 1'b1;
        iss_z = 32'h4000_0000;
        iss_st = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) issue = 1'b0;
            chk("single_valid", 32'(out_valid), 32'(k == 3));
            if (k == 3) begin
                chk("single_z", out_z, 32'h4000_0000);
                chk("single_status", 32'(out_status), 32'h00);
            end
        end
        chk("single_count", 32'(result_count), 32'(1));

        // Six issues against a stalled consumer: four fit, the fifth overflows.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("credit_ready", 32'(issue_ready), 32'(i < 4));
            chk("credit_err", 32'(err_overflow), 32'(i == 5));
            issue = 1'b1;
            iss_z = 32'hA000_0000 + 32'(i);
            iss_st = 8'(1 << ((i % 2 == 0) ? STATUS_ZERO : STATUS_TINY));
        end
        @(negedge clk);
        issue = 1'b0;
        chk("overflow_sticky", 32'(err_overflow), 32'(1));
        out_ready = 1'b1;
        begin
            int got = 0;
            for (int k = 0; k < 20 && got < 4; k++) begin
                if (out_valid) begin
                    chk("drain_order", out_z, 32'hA000_0000 + 32'(got));
                    got++;
                end
                @(negedge clk);
            end
            chk("drain_count", 32'(got), 32'(4));
        end
        repeat (3) @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'(0));

        // Sticky status accumulation, then clear coinciding with a delivery.
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        chk("clear_acc", 32'(acc_status), 32'(0));
        chk("clear_err", 32'(err_overflow), 32'(0));
        issue = 1'b1;
        iss_st = 8'(1 << STATUS_INEXACT);
        @(negedge clk) iss_st = 8'(1 << STATUS_INF);
        @(negedge clk) issue = 1'b0;
        wait_drain("acc_drain");
        chk("acc_or", 32'(acc_status), 32'h22);
        out_ready = 1'b0;
        issue = 1'b1;
        iss_st = 8'(1 << STATUS_NAN);
        @(negedge clk) issue = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++)
            @(negedge clk);
        chk("clr_dlv_wait", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        clear = 1'b0;
        chk("clear_with_delivery", 32'(acc_status), 32'h04);

        // 1000 accepted random results with the consumer ready every other cycle.
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        issue = 1'b1;
        for (int k = 0; k < 5000 && n_acc < 1000; k++) begin
            iss_z = $urandom;
            iss_st = 8'($urandom_range(0, 255));
            out_ready = k[0];
            @(negedge clk);
        end
        issue = 1'b0;
        out_ready = 1'b1;
        chk("random_accepted", 32'(n_acc), 32'(1000));
        wait_drain("random_drain");
        chk("random_count", 32'(result_count), 32'(1000));

        // Delivery counter wrap at 0xFFFF.
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        issue = 1'b1;
        iss_st = 8'(1 << STATUS_HUGE);
        @(negedge clk) iss_st = 8'h00;
        for (int k = 0; k < 70000 && n_acc < 65535; k++)
            @(negedge clk);
        issue = 1'b0;
        wait_drain("wrap_drain");
        chk("wrap_preload", 32'(result_count), 32'hFFFF);
        chk("wrap_preload_acc", 32'(acc_status), 32'h10);
        issue = 1'b1;
        @(negedge clk) issue = 1'b0;
        wait_drain("wrap_last_drain");
        chk("wrap_zero", 32'(result_count), 32'h0000);
        chk("wrap_acc", 32'(acc_status), 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
